wavefront_router: RTL

WAVEFRONT_ROUTER -- requirements
Module: wavefront_router

---
 rtl/wavefront_router.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/wavefront_router.sv
// wavefront_router: breadth-first wavefront search over an undirected edge list.
// Define WAVEFRONT_ROUTE_TRACE_EN to add parent storage and the TRACE state (single shortest path).
module wavefront_router #(
  parameter  int NODES = 64,
  parameter  int EDGES = 128,
  localparam int NW    = $clog2(NODES)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [NW-1:0]       startPoint,
  input  logic [NW-1:0]       endPoint,
  input  logic [EDGES-1:0]    edgeMask,
  input  logic [EDGES*NW-1:0] edgeA,
  input  logic [EDGES*NW-1:0] edgeB,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [NW:0]         hopCount,
  output logic [EDGES-1:0]    activeRoute
);
  // Reached vector spans the full index space so any NW-bit endpoint indexes safely.
  localparam int          NP      = 1 << NW;
  localparam logic [NW:0] NODES_L = (NW+1)'(NODES);
  localparam logic [NW:0] HOP_MAX = (NW+1)'(NODES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
`ifdef WAVEFRONT_ROUTE_TRACE_EN
    TRACE  = 2'd2,
`endif
    FINISH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    end_q, end_d;
  logic [EDGES-1:0] mask_q, mask_d;
  logic [EDGES-1:0] route_q, route_d;
  logic [EDGES-1:0] carry;
  logic [NP-1:0]    reached_q, reached_d;
  logic [NP-1:0]    new_v;
  logic [NW:0]      hop_q, hop_d, hop_inc;
  logic             found_q, found_d;
  logic [NW-1:0]    ea, eb, nn;

`ifdef WAVEFRONT_ROUTE_TRACE_EN
  localparam int EW = (EDGES > 1) ? $clog2(EDGES) : 1;
  logic [NW-1:0] start_q, start_d;
  logic [NW-1:0] cur_q, cur_d;
  logic [NW-1:0] ta, tb;
  logic [EW-1:0] pe;
  logic [EW-1:0] parent_q [NP];
  logic [EW-1:0] parent_d [NP];
`endif

  // One wavefront step: every unmasked edge with exactly one reached end carries it;
  // scanning upward makes the lowest-index carrying edge the recorded parent.
  always_comb begin
    carry = '0;
    new_v = '0;
    ea    = '0;
    eb    = '0;
    nn    = '0;
`ifdef WAVEFRONT_ROUTE_TRACE_EN
    parent_d = parent_q;
`endif
    for (int e = 0; e < EDGES; e++) begin
      ea = edgeA[e*NW +: NW];
      eb = edgeB[e*NW +: NW];
      if (!mask_q[e] && (reached_q[ea] ^ reached_q[eb])) begin
        carry[e] = 1'b1;
        nn       = reached_q[ea] ? eb : ea;
        if (!new_v[nn]) begin
          new_v[nn] = 1'b1;
`ifdef WAVEFRONT_ROUTE_TRACE_EN
          parent_d[nn] = EW'(e);
`endif
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    end_d     = end_q;
    mask_d    = mask_q;
    route_d   = route_q;
    reached_d = reached_q;
    hop_d     = hop_q;
    found_d   = found_q;
    hop_inc   = hop_q + 1'b1;
`ifdef WAVEFRONT_ROUTE_TRACE_EN
    start_d = start_q;
    cur_d   = cur_q;
    pe      = parent_q[cur_q];
    ta      = edgeA[int'(pe)*NW +: NW];
    tb      = edgeB[int'(pe)*NW +: NW];
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          end_d                 = endPoint;
          mask_d                = edgeMask;
          reached_d             = '0;
          reached_d[startPoint] = 1'b1;
          route_d               = '0;
          hop_d                 = '0;
          found_d               = 1'b0;
`ifdef WAVEFRONT_ROUTE_TRACE_EN
          start_d = startPoint;
`endif
          if (({1'b0, startPoint} >= NODES_L) || ({1'b0, endPoint} >= NODES_L)) begin
            state_d = FINISH;
          end else if (startPoint == endPoint) begin
            found_d = 1'b1;
            state_d = FINISH;
          end else begin
            state_d = EXPAND;
          end
        end
      end
      EXPAND: begin
        // A stalled wavefront means the target is unreachable; hopCount stays at the last real hop.
        if (new_v == '0) begin
          state_d = FINISH;
        end else begin
          reached_d = reached_q | new_v;
          hop_d     = hop_inc;
`ifndef WAVEFRONT_ROUTE_TRACE_EN
          route_d = route_q | carry;
`endif
          if (new_v[end_q]) begin
            found_d = 1'b1;
`ifdef WAVEFRONT_ROUTE_TRACE_EN
            cur_d   = end_q;
            state_d = TRACE;
`else
            state_d = FINISH;
`endif
          end else if (hop_inc == HOP_MAX) begin
            state_d = FINISH;
          end
        end
      end
`ifdef WAVEFRONT_ROUTE_TRACE_EN
      TRACE: begin
        route_d[pe] = 1'b1;
        cur_d       = (ta == cur_q) ? tb : ta;
        if (cur_d == start_q) state_d = FINISH;
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      end_q     <= '0;
      mask_q    <= '0;
      route_q   <= '0;
      reached_q <= '0;
      hop_q     <= '0;
      found_q   <= 1'b0;
`ifdef WAVEFRONT_ROUTE_TRACE_EN
      start_q <= '0;
      cur_q   <= '0;
      for (int n = 0; n < NP; n++) parent_q[n] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      end_q     <= end_d;
      mask_q    <= mask_d;
      route_q   <= route_d;
      reached_q <= reached_d;
      hop_q     <= hop_d;
      found_q   <= found_d;
`ifdef WAVEFRONT_ROUTE_TRACE_EN
      start_q <= start_d;
      cur_q   <= cur_d;
      if (state_q == EXPAND) parent_q <= parent_d;
`endif
    end
  end

`ifdef WAVEFRONT_ROUTE_TRACE_EN
  assign busy = (state_q == EXPAND) || (state_q == TRACE);
`else
  assign busy = (state_q == EXPAND);
`endif
  assign done        = (state_q == FINISH);
  assign found       = found_q;
  assign hopCount    = hop_q;
  assign activeRoute = route_q;

endmodule
